// File: rtl/core_seq_fsm_if.sv
// Memory-side handshake bundle for the core sequencer: instruction fetch and
// data access. The sequencer is the master; the memory model or fabric is the slave.
interface core_seq_fsm_if;
  logic        imem_req_o;
  logic        imem_valid_i;
  logic [31:0] imem_rdata_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        dmem_ready_i;

  modport master (
    output imem_req_o, dmem_req_o, dmem_we_o,
    input  imem_valid_i, imem_rdata_i, dmem_ready_i
  );

  modport slave (
    input  imem_req_o, dmem_req_o, dmem_we_o,
    output imem_valid_i, imem_rdata_i, dmem_ready_i
  );
endinterface

// File: rtl/core_seq_fsm.sv
// Multi-cycle core sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP
// for illegal opcodes and memory-wait timeouts. Counts retired instructions.
module core_seq_fsm #(
  parameter logic [7:0] WDT_MAX = 8'd255
) (
  input  logic                 clk_i,
  input  logic                 cntrst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 clear_i,
  core_seq_fsm_if.master       mem,
  output logic [31:0]          ir_o,
  input  logic                 rwr_en_i,
  output logic                 rf_we_o,
  output logic                 pc_en_o,
  output logic                 illegal_o,
  output logic [2:0]           state_o,
  output logic [31:0]          instr_cnt_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q;
  logic [31:0] instr_cnt_q;
  logic [7:0]  wait_q;
  logic        illegal_q;

  logic [6:0]  opcode;
  logic        is_load, is_store, is_legal;
  logic        timeout;
  logic        store_done;

  assign opcode   = ir_q[6:0];
  assign is_load  = (opcode == 7'h03);
  assign is_store = (opcode == 7'h23);

  // Opcode whitelist checked in DECODE.
  always_comb begin
    is_legal = 1'b0;
    case (opcode)
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h23,
      7'h63, 7'h37, 7'h17, 7'h6F, 7'h33: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  end

  // wait_q is 0 in the first waiting cycle, so the WDT_MAX-th waiting cycle
  // without a handshake is the last one before trapping.
  assign timeout    = (wait_q == WDT_MAX - 8'd1);
  assign store_done = (state_q == MEM) && mem.dmem_ready_i && is_store;

  // State register.
  always_ff @(posedge clk_i or negedge cntrst_i) begin
    if (!cntrst_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic; stop_i is only looked at when an instruction retires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start_i) state_d = FETCH;
      FETCH: begin
        if (mem.imem_valid_i) state_d = DECODE;
        else if (timeout)     state_d = TRAP;
      end
      DECODE: begin
        if (!is_legal)                state_d = TRAP;
        else if (is_load || is_store) state_d = MEM;
        else                          state_d = EXEC;
      end
      EXEC:   state_d = WB;
      MEM: begin
        if (mem.dmem_ready_i) begin
          if (is_store) state_d = stop_i ? IDLE : FETCH;
          else          state_d = WB;
        end else if (timeout) begin
          state_d = TRAP;
        end
      end
      WB:     state_d = stop_i ? IDLE : FETCH;
      TRAP:   if (clear_i) state_d = IDLE;
      default: state_d = TRAP;
    endcase
  end

  // Output decode; TRAP and the unused code fall through to all-zero.
  always_comb begin
    mem.imem_req_o = (state_q == FETCH);
    mem.dmem_req_o = (state_q == MEM);
    mem.dmem_we_o  = (state_q == MEM) && is_store;
    rf_we_o        = (state_q == WB) && (rwr_en_i || is_load);
    pc_en_o        = (state_q == WB) || store_done;
  end

  // Datapath registers: instruction latch, retire counter, wait watchdog, trap flag.
  always_ff @(posedge clk_i or negedge cntrst_i) begin
    if (!cntrst_i) begin
      ir_q        <= '0;
      instr_cnt_q <= '0;
      wait_q      <= '0;
      illegal_q   <= 1'b0;
    end else begin
      if (state_q == FETCH && mem.imem_valid_i) ir_q <= mem.imem_rdata_i;
      if (pc_en_o) instr_cnt_q <= instr_cnt_q + 32'd1;
      if (state_d != state_q)                      wait_q <= '0;
      else if (state_q == FETCH || state_q == MEM) wait_q <= wait_q + 8'd1;
      if (state_d == TRAP)                         illegal_q <= 1'b1;
      else if (state_q == TRAP && clear_i)         illegal_q <= 1'b0;
    end
  end

  assign ir_o        = ir_q;
  assign illegal_o   = illegal_q;
  assign state_o     = state_q;
  assign instr_cnt_o = instr_cnt_q;

endmodule

// File: tb/tb_core_seq_fsm.sv
// Directed bench for core_seq_fsm: ALU, store, illegal, timeout, wrap, reset, stop.
module tb_core_seq_fsm;
  logic        clk_i = 1'b0;
  logic        cntrst_i;
  logic        start_i, stop_i, clear_i, rwr_en_i;
  logic [31:0] ir_o, instr_cnt_o;
  logic        rf_we_o, pc_en_o, illegal_o;
  logic [2:0]  state_o;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n;

  core_seq_fsm_if mem ();

  core_seq_fsm dut (
    .clk_i(clk_i), .cntrst_i(cntrst_i), .start_i(start_i), .stop_i(stop_i),
    .clear_i(clear_i), .mem(mem.master), .ir_o(ir_o), .rwr_en_i(rwr_en_i),
    .rf_we_o(rf_we_o), .pc_en_o(pc_en_o), .illegal_o(illegal_o),
    .state_o(state_o), .instr_cnt_o(instr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards apply to the next edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    cntrst_i = 1'b0; start_i = 0; stop_i = 0; clear_i = 0; rwr_en_i = 0;
    mem.imem_valid_i = 0; mem.imem_rdata_i = '0; mem.dmem_ready_i = 0;
    #12;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_ir", ir_o, 0);
    chk("rst_cnt", instr_cnt_o, 0);
    chk("rst_ill", 32'(illegal_o), 0);
    chk("rst_ireq", 32'(mem.imem_req_o), 0);
    cntrst_i = 1'b1;
    cyc(); cyc();
    chk("idle_hold", 32'(state_o), 0);

    // ALU: addi, immediate fetch data, stop in WB.
    start_i = 1; mem.imem_valid_i = 1; mem.imem_rdata_i = 32'h00500093; rwr_en_i = 1; stop_i = 1;
    cyc(); start_i = 0; #1;
    chk("alu_fetch", 32'(state_o), 1);
    chk("alu_ireq", 32'(mem.imem_req_o), 1);
    cyc(); mem.imem_valid_i = 0; #1;
    chk("alu_dec", 32'(state_o), 2);
    chk("alu_ir", ir_o, 32'h00500093);
    cyc();
    chk("alu_exec", 32'(state_o), 3);
    chk("alu_exec_pc", 32'(pc_en_o), 0);
    cyc();
    chk("alu_wb", 32'(state_o), 5);
    chk("alu_wb_rfwe", 32'(rf_we_o), 1);
    chk("alu_wb_pc", 32'(pc_en_o), 1);
    cyc();
    chk("alu_idle", 32'(state_o), 0);
    chk("alu_cnt", instr_cnt_o, 1);
    chk("alu_pc_off", 32'(pc_en_o), 0);

    // Store, ready on the third MEM cycle, continue to FETCH.
    stop_i = 0; start_i = 1; mem.imem_valid_i = 1; mem.imem_rdata_i = 32'h00112023;
    cyc(); start_i = 0;
    cyc(); mem.imem_valid_i = 0; #1;
    chk("st_dec", 32'(state_o), 2);
    cyc();
    chk("st_mem1", 32'(state_o), 4);
    chk("st_we1", 32'(mem.dmem_we_o), 1);
    chk("st_req1", 32'(mem.dmem_req_o), 1);
    chk("st_rf1", 32'(rf_we_o), 0);
    chk("st_pc1", 32'(pc_en_o), 0);
    cyc();
    chk("st_we2", 32'(mem.dmem_we_o), 1);
    chk("st_pc2", 32'(pc_en_o), 0);
    cyc(); mem.dmem_ready_i = 1; #1;
    chk("st_we3", 32'(mem.dmem_we_o), 1);
    chk("st_pc3", 32'(pc_en_o), 1);
    chk("st_rf3", 32'(rf_we_o), 0);
    cyc(); mem.dmem_ready_i = 0; #1;
    chk("st_fetch", 32'(state_o), 1);
    chk("st_cnt", instr_cnt_o, 2);
    chk("st_we_off", 32'(mem.dmem_we_o), 0);
    chk("st_pc_off", 32'(pc_en_o), 0);

    // Illegal opcode straight from FETCH; start ignored in TRAP.
    mem.imem_valid_i = 1; mem.imem_rdata_i = 32'h0000007F;
    cyc(); mem.imem_valid_i = 0; #1;
    chk("ill_dec", 32'(state_o), 2);
    cyc();
    chk("ill_trap", 32'(state_o), 7);
    chk("ill_flag", 32'(illegal_o), 1);
    chk("ill_ireq", 32'(mem.imem_req_o), 0);
    start_i = 1;
    cyc(); cyc(); start_i = 0; #1;
    chk("ill_hold", 32'(state_o), 7);
    chk("ill_flag_hold", 32'(illegal_o), 1);
    chk("ill_cnt", instr_cnt_o, 2);
    clear_i = 1;
    cyc(); clear_i = 0; #1;
    chk("ill_clr_state", 32'(state_o), 0);
    chk("ill_clr_flag", 32'(illegal_o), 0);

    // Load with no dmem_ready: watchdog trap after 255 MEM cycles.
    start_i = 1; mem.imem_valid_i = 1; mem.imem_rdata_i = 32'h00002083;
    cyc(); start_i = 0;
    cyc(); mem.imem_valid_i = 0;
    cyc();
    chk("ld_mem", 32'(state_o), 4);
    chk("ld_we", 32'(mem.dmem_we_o), 0);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (state_o != 3'd4) break;
      n++;
      cyc();
    end
    chk("wdt_cycles", n, 255);
    chk("wdt_trap", 32'(state_o), 7);
    chk("wdt_dreq", 32'(mem.dmem_req_o), 0);
    chk("wdt_flag", 32'(illegal_o), 1);
    clear_i = 1;
    cyc(); clear_i = 0; #1;
    chk("wdt_clr", 32'(state_o), 0);

    // Counter wrap across two retired instructions.
    chk("wrap_pre", instr_cnt_o, 2);
    force dut.instr_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.instr_cnt_q;
    start_i = 1; mem.imem_valid_i = 1; mem.imem_rdata_i = 32'h00500093; stop_i = 0;
    cyc(); start_i = 0;
    cyc(); cyc(); cyc();
    chk("wrap_wb1", 32'(state_o), 5);
    chk("wrap_cnt0", instr_cnt_o, 32'hFFFF_FFFE);
    cyc(); stop_i = 1; #1;
    chk("wrap_fetch", 32'(state_o), 1);
    chk("wrap_cnt1", instr_cnt_o, 32'hFFFF_FFFF);
    cyc(); mem.imem_valid_i = 0;
    cyc(); cyc(); cyc();
    chk("wrap_idle", 32'(state_o), 0);
    chk("wrap_cnt2", instr_cnt_o, 0);

    // Reset in the middle of a load's MEM phase.
    stop_i = 0; start_i = 1; mem.imem_valid_i = 1; mem.imem_rdata_i = 32'h00002083;
    cyc(); start_i = 0;
    cyc(); mem.imem_valid_i = 0;
    cyc(); cyc();
    chk("rmem_state", 32'(state_o), 4);
    cntrst_i = 0; #1;
    chk("rmem_state0", 32'(state_o), 0);
    chk("rmem_dreq", 32'(mem.dmem_req_o), 0);
    chk("rmem_ir", ir_o, 0);
    chk("rmem_cnt", instr_cnt_o, 0);
    cyc(); cntrst_i = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rmem_noretry", 32'({state_o, mem.imem_req_o}), 0);
    end

    // stop_i in WB returns to IDLE and stops fetching.
    start_i = 1; mem.imem_valid_i = 1; mem.imem_rdata_i = 32'h00500093; stop_i = 1;
    cyc(); start_i = 0;
    cyc(); mem.imem_valid_i = 0;
    cyc(); cyc(); cyc();
    chk("stop_idle", 32'(state_o), 0);
    chk("stop_cnt", instr_cnt_o, 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("stop_noreq", 32'(mem.imem_req_o), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
